// File: rtl/dkong_wav_player_if.sv
// Sample-ROM read port shared by the wave player and the ROM arbiter.
// The player drives address/request; the ROM side returns acknowledge plus data.
interface dkong_wav_player_if #(
  parameter int ROM_AW = 19
);
  logic [ROM_AW-1:0] rom_ab;
  logic              rom_rd;
  logic              rom_ack;
  logic [7:0]        rom_data;

  modport master (output rom_ab, rom_rd, input rom_ack, rom_data);
  modport slave  (input rom_ab, rom_rd, output rom_ack, rom_data);
endinterface

// File: rtl/dkong_wav_player.sv
// Single-voice, priority-arbitrated wave-sample player for the Donkey Kong sound board.
// Define WAV_LOOP_EN to let triggers with TRIG_LOOP set repeat while held high.
module dkong_wav_player #(
  parameter int                      CLOCK_RATE  = 24000000,
  parameter int                      SAMPLE_RATE = 11025,
  parameter int                      NUM_TRIG    = 4,
  parameter int                      ROM_AW      = 19,
  parameter logic [ROM_AW-1:0]       ROM_BASE    = 19'h10000,
  parameter logic [16*NUM_TRIG-1:0]  TRIG_ADR    = {16'h0800, 16'h0000, 16'h1000, 16'h3000},
  parameter logic [16*NUM_TRIG-1:0]  TRIG_LEN    = {16'h07d0, 16'h07d0, 16'h1e20, 16'h1750},
  parameter logic [2*NUM_TRIG-1:0]   TRIG_PRI    = {2'd2, 2'd2, 2'd3, 2'd1},
  parameter logic [NUM_TRIG-1:0]     TRIG_LOOP   = 4'b0000
) (
  input  logic                I_CLK,
  input  logic                I_RST,
  input  logic [NUM_TRIG-1:0] I_TRIG,
  dkong_wav_player_if.master  rom,
  output logic [7:0]          O_WAV,
  output logic                O_BUSY,
  output logic [2:0]          O_ID
);

  localparam logic [11:0] DIV = 12'(CLOCK_RATE / SAMPLE_RATE);

  typedef enum logic [1:0] {IDLE, PLAY, FETCH} state_t;

  state_t              state, state_nxt;
  logic [11:0]         div;
  logic                tick;
  logic [NUM_TRIG-1:0] trig_q, trig_qq, rise;
  logic                req_vld;
  logic [2:0]          req_id;
  logic [15:0]         ad, cnt;
  logic                discard;
  logic                pend_mid;

  logic                best_vld;
  logic [2:0]          best_id;
  logic [1:0]          best_pri;
  logic [1:0]          req_pri, cur_pri;
  logic [15:0]         req_adr, req_len, cur_adr, cur_len;
  logic                start, ack_seen, accept, last, reload, issue;

  always_comb rise = trig_q & ~trig_qq;

  // Strict '>' keeps the lowest index on equal priority; empty samples never compete.
  always_comb begin
    best_vld = 1'b0;
    best_id  = '0;
    best_pri = '0;
    for (int unsigned i = 0; i < NUM_TRIG; i++) begin
      if (rise[i] && (TRIG_LEN[16*i +: 16] != '0) &&
          (!best_vld || (TRIG_PRI[2*i +: 2] > best_pri))) begin
        best_vld = 1'b1;
        best_id  = 3'(i);
        best_pri = TRIG_PRI[2*i +: 2];
      end
    end
  end

  always_comb begin
    req_pri = '0;
    req_adr = '0;
    req_len = '0;
    cur_pri = '0;
    cur_adr = '0;
    cur_len = '0;
    for (int unsigned i = 0; i < NUM_TRIG; i++) begin
      if (3'(i) == req_id) begin
        req_pri = TRIG_PRI[2*i +: 2];
        req_adr = TRIG_ADR[16*i +: 16];
        req_len = TRIG_LEN[16*i +: 16];
      end
      if (3'(i) == O_ID) begin
        cur_pri = TRIG_PRI[2*i +: 2];
        cur_adr = TRIG_ADR[16*i +: 16];
        cur_len = TRIG_LEN[16*i +: 16];
      end
    end
  end

`ifdef WAV_LOOP_EN
  logic cur_loop;

  always_comb begin
    cur_loop = 1'b0;
    for (int unsigned i = 0; i < NUM_TRIG; i++) begin
      if (3'(i) == O_ID) cur_loop = TRIG_LOOP[i] & trig_q[i];
    end
  end

  always_comb reload = last & cur_loop;
`else
  logic unused_loop;

  always_comb unused_loop = ^TRIG_LOOP;
  always_comb reload = 1'b0;
`endif

  always_comb begin
    start     = req_vld && ((state == IDLE) || (req_pri > cur_pri));
    ack_seen  = rom.rom_rd & rom.rom_ack;
    // A preempted request may still be in flight while in PLAY; no new fetch until it retires.
    accept    = (state == FETCH) && ack_seen && !start;
    last      = accept && (cnt == 16'd1);
    issue     = (state == PLAY) && tick && !rom.rom_rd && !start;
    state_nxt = state;
    if (start) begin
      state_nxt = PLAY;
    end else begin
      unique case (state)
        IDLE:    state_nxt = IDLE;
        PLAY:    if (issue) state_nxt = FETCH;
        FETCH:   if (accept) state_nxt = (last && !reload) ? IDLE : PLAY;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state      <= IDLE;
      div        <= '0;
      tick       <= 1'b0;
      trig_q     <= '1;
      trig_qq    <= '1;
      req_vld    <= 1'b0;
      req_id     <= '0;
      ad         <= '0;
      cnt        <= '0;
      discard    <= 1'b0;
      pend_mid   <= 1'b0;
      rom.rom_rd <= 1'b0;
      rom.rom_ab <= ROM_BASE;
      O_WAV      <= 8'h80;
      O_BUSY     <= 1'b0;
      O_ID       <= '0;
    end else begin
      state   <= state_nxt;
      trig_q  <= I_TRIG;
      trig_qq <= trig_q;
      req_vld <= best_vld;
      req_id  <= best_id;

      div  <= (div == DIV - 12'd1) ? '0 : div + 12'd1;
      tick <= (div == DIV - 12'd1);

      if (issue) begin
        rom.rom_rd <= 1'b1;
        rom.rom_ab <= ROM_BASE + ROM_AW'(ad);
      end else if (ack_seen) begin
        rom.rom_rd <= 1'b0;
      end

      if (start && rom.rom_rd && !ack_seen) discard <= 1'b1;
      else if (ack_seen)                    discard <= 1'b0;

      if (start) begin
        ad     <= req_adr;
        cnt    <= req_len;
        O_ID   <= req_id;
        O_BUSY <= 1'b1;
      end else if (accept) begin
        if (reload) begin
          ad  <= cur_adr;
          cnt <= cur_len;
        end else begin
          ad  <= ad + 16'd1;
          cnt <= cnt - 16'd1;
        end
        if (last && !reload) begin
          O_BUSY <= 1'b0;
          O_ID   <= '0;
        end
      end

      if (accept)                pend_mid <= last && !reload;
      else if (tick)             pend_mid <= 1'b0;

      if (accept)                O_WAV <= rom.rom_data;
      else if (tick && pend_mid) O_WAV <= 8'h80;
    end
  end

endmodule

// File: doc/dkong_wav_player.md
# dkong_wav_player

Parametrised single-voice wave-sample player for the Donkey Kong sound board. It generalises the fixed walk/jump/foot sample sequencer to NUM_TRIG triggers, each with its own ROM start address, length and priority. ROM reads use a request/acknowledge handshake, and the block holds the fetched 8-bit sample for the DAC/mixer. It sits between the sound-latch trigger bits and the shared sample ROM port.

## Interface
- CLOCK_RATE, 24000000, system clock in Hz.
- SAMPLE_RATE, 11025, playback rate in Hz; DIV = CLOCK_RATE/SAMPLE_RATE, truncated, 12-bit.
- NUM_TRIG, 4, number of trigger inputs (1..8).
- ROM_AW, 19, ROM address width.
- ROM_BASE, 19'h10000, base added to every sample offset.
- TRIG_ADR, {16'h0800,16'h0000,16'h1000,16'h3000}, packed 16-bit start offsets; trigger i is at [16i+:16].
- TRIG_LEN, {16'h07d0,16'h07d0,16'h1e20,16'h1750}, packed 16-bit lengths in samples.
- TRIG_PRI, {2'd2,2'd2,2'd3,2'd1}, packed 2-bit priorities; higher value wins.
- TRIG_LOOP, 4'b0000, per-trigger loop enable; used only with WAV_LOOP_EN.
- I_CLK  in  1  system clock.
- I_RST  in  1  synchronous, active-high reset.
- I_TRIG  in  NUM_TRIG  trigger levels; a rising edge requests playback.
- O_ROM_AB  out  ROM_AW  ROM address.
- O_ROM_RD  out  1  ROM read request.
- I_ROM_ACK  in  1  ROM read acknowledge; I_ROM_DATA is valid in the same cycle.
- I_ROM_DATA  in  8  ROM data.
- O_WAV  out  8  unsigned sample output, midpoint 8'h80.
- O_BUSY  out  1  high while a sample is playing.
- O_ID  out  3  index of the playing trigger (0 when idle).

## Operation
- Reset values: O_WAV=8'h80, O_ROM_RD=0, O_BUSY=0, O_ID=0, O_ROM_AB=ROM_BASE, divider=0, trigger history registers all-ones. A trigger held high through reset does not fire.
- Tick divider:
  - free-running 0..DIV-1;
  - a one-cycle tick is registered on the cycle after the counter reaches DIV-1;
  - starting a sample never resets the divider.
- Edge detection: I_TRIG is registered into trig_q and again into trig_qq; rise = trig_q & ~trig_qq.
- Arbitration:
  - among rising triggers in the same cycle, the highest TRIG_PRI wins; ties go to the lowest index;
  - the winner starts only if the block is idle, or its priority is strictly greater than the playing trigger's;
  - equal or lower priority requests are discarded, not queued;
  - a trigger with TRIG_LEN=0 is never started.
- Start: loads ad=TRIG_ADR[i] and cnt=TRIG_LEN[i], sets O_ID=i and O_BUSY=1, state=PLAY.
- States:
  - IDLE -> PLAY on start.
  - PLAY -> FETCH on tick: assert O_ROM_RD with O_ROM_AB = ROM_BASE + ad (16-bit ad zero-extended).
  - FETCH -> PLAY on I_ROM_ACK: O_WAV <= I_ROM_DATA, ad <= ad+1 (16-bit wrap), cnt <= cnt-1. If cnt becomes 0: state IDLE, O_BUSY=0, O_ID=0, O_WAV=8'h80 on the following tick.
- Handshake:
  - O_ROM_RD stays high and O_ROM_AB stays stable until I_ROM_ACK is seen;
  - I_ROM_ACK while O_ROM_RD is low is ignored;
  - O_ROM_RD drops in the cycle after the ack.
- Preempt during FETCH:
  - the new trigger's ad/cnt/O_ID load immediately, but the outstanding request completes unchanged;
  - data from the aborted request is discarded and O_WAV is not updated;
  - state returns to PLAY.
- Tick during FETCH: the tick is dropped; there is no backlog.
- Reset mid-operation: all state returns to reset values on the next edge; any outstanding request is abandoned and O_ROM_RD drops.

## Timing
- Trigger rising at edge N (sampled into trig_q) -> O_BUSY/O_ID valid after edge N+2.
- First fetch is issued on the first tick after start.
- Fetch latency is one cycle beyond the ack: O_WAV updates on the edge that samples I_ROM_ACK.
- With zero-wait ROM (ack in the cycle after RD), a sample of length L completes in L ticks.

## Configuration
- WAV_LOOP_EN defined:
  - when cnt reaches 0 for trigger i with TRIG_LOOP[i]=1 and trig_q[i] still high, ad/cnt reload from TRIG_ADR/TRIG_LEN and playback continues without returning to IDLE;
  - if trig_q[i] is low, the block goes idle as normal.
- WAV_LOOP_EN undefined: TRIG_LOOP is ignored and every sample is one-shot; loop logic is not synthesised.

## Test plan
- Single foot: pulse I_TRIG[0]. Expected: first O_ROM_AB=19'h13000, exactly 16'h1750 acks, last address 19'h1474F, then O_BUSY=0 and O_WAV=8'h80.
- Preempt: start trigger 0, then pulse trigger 1 after 100 samples. Expected: next address 19'h11000 and O_ID=1. Then pulse trigger 0 while trigger 1 plays. Expected: ignored, 16'h1e20 samples play.
- Simultaneous: rise I_TRIG[2] and I_TRIG[3] in the same cycle. Expected: O_ID=2, first O_ROM_AB=19'h10000.
- Slow ROM: delay ack by 3000 cycles. Expected: O_ROM_AB stable during the wait, ticks dropped, no double increment; preempt during the wait discards that data.
- Reset mid-fetch: assert I_RST with O_ROM_RD high. Expected: after the next edge, O_ROM_RD=0, O_BUSY=0, O_WAV=8'h80. A held trigger does not restart after reset release.
- Loop (WAV_LOOP_EN, TRIG_LOOP=4'b0001): hold I_TRIG[0] high. Expected: address wraps 19'h1474F -> 19'h13000 with no idle cycle. Release I_TRIG[0]. Expected: block goes idle at the end of the current pass.
